mult_control: RTL and testbench

MULT_CONTROL -- requirements
Module: mult_control

---
 rtl/mult_control.sv | 119 +++++++++++
 tb/tb_mult_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// rtl/mult_control.sv - Sequencer for a WIDTH-bit add/shift two's-complement multiplier
module mult_control #(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Ld_B,
  output logic Clr_AX,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HOLD
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  i, i_next;
  // Set on the edge that leaves the final SHIFT, so it is high only for the first HOLD cycle.
  logic           done_flag, done_flag_next;

  // State, iteration counter and first-HOLD-cycle flag; reset aborts any multiply at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      i         <= '0;
      done_flag <= 1'b0;
    end else begin
      state     <= state_next;
      i         <= i_next;
      done_flag <= done_flag_next;
    end
  end

  // Next state, counter update and output decode.
  always_comb begin
    state_next     = state;
    i_next         = i;
    done_flag_next = 1'b0;
    Ld_B           = 1'b0;
    Clr_AX         = 1'b0;
    Add            = 1'b0;
    Sub            = 1'b0;
    Shift          = 1'b0;
    Busy           = 1'b0;
    Done           = 1'b0;

    case (state)
      IDLE: begin
        // Run takes priority: a start never also reloads B.
        if (Run) begin
          state_next = CLEAR;
        end else if (ClearA_LoadB) begin
          Ld_B   = 1'b1;
          Clr_AX = 1'b1;
        end
      end
      CLEAR: begin
        Clr_AX     = 1'b1;
        Busy       = 1'b1;
        i_next     = '0;
        state_next = ADD;
      end
      ADD: begin
        Add        = M;
        // The last multiplier bit is the sign bit, so its partial product is subtracted.
        Sub        = M && (i == LAST);
        Busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        if (i == LAST) begin
          done_flag_next = 1'b1;
          state_next     = HOLD;
        end else begin
          i_next     = i + IW'(1);
          state_next = ADD;
        end
      end
      HOLD: begin
        Done = done_flag;
        if (!Run) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        i_next     = '0;
      end
    endcase

    // While reset is held every output is forced low, including the IDLE load strobes.
    if (!Reset) begin
      Ld_B   = 1'b0;
      Clr_AX = 1'b0;
      Add    = 1'b0;
      Sub    = 1'b0;
      Shift  = 1'b0;
      Busy   = 1'b0;
      Done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - Randomized self-checking bench for mult_control
module tb_mult_control;

  localparam int W = 8;

  logic Clk;
  logic Reset;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Ld_B, Clr_AX, Add, Sub, Shift, Busy, Done;

  int checks = 0;
  int errors = 0;

  // Output bit positions in the packed observation vector.
  localparam int P_LDB = 6, P_CLR = 5, P_ADD = 4, P_SUB = 3, P_SHF = 2, P_BSY = 1, P_DON = 0;

  mult_control #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Ld_B         (Ld_B),
    .Clr_AX       (Clr_AX),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [6:0] outs();
    return {Ld_B, Clr_AX, Add, Sub, Shift, Busy, Done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: cycle c counts edges after the one that sampled Run in IDLE.
  // c=1 CLEAR, c=2+2k ADD k, c=3+2k SHIFT k, c>=2W+2 HOLD with Done only at c=2W+2.
  function automatic logic [6:0] expect_out(input int c, input logic [W-1:0] b);
    logic [6:0] e;
    int k;
    e = '0;
    if (c == 1) begin
      e[P_CLR] = 1'b1;
      e[P_BSY] = 1'b1;
    end else if (c >= 2 && c <= 2 * W + 1) begin
      k = (c - 2) / 2;
      e[P_BSY] = 1'b1;
      if ((c % 2) == 0) begin
        e[P_ADD] = b[k];
        e[P_SUB] = b[k] && (k == W - 1);
      end else begin
        e[P_SHF] = 1'b1;
      end
    end else if (c == 2 * W + 2) begin
      e[P_DON] = 1'b1;
    end
    return e;
  endfunction

  task automatic idle_cycles(input int n, input bit force_load);
    logic [6:0] e;
    for (int j = 0; j < n; j++) begin
      @(negedge Clk);
      Reset        = 1'b1;
      Run          = 1'b0;
      ClearA_LoadB = force_load ? 1'b1 : 1'($urandom);
      M            = 1'($urandom);
      #1;
      e = ClearA_LoadB ? 7'b1100000 : 7'b0000000;
      check($sformatf("idle_load[%0d]", j), 32'(outs()), 32'(e));
    end
  endtask

  // One multiply; abort_at >= 0 pulls Reset low in that cycle and leaves Run high for the next start.
  task automatic do_mult(input logic [W-1:0] b, input int hold_extra, input bit clr_with_run,
                         input int abort_at);
    int last;
    int nshift, nadd, nclr, nbusy, ndone, nldb;
    logic [6:0] got, e;
    bit aborted;
    last    = 2 * W + 2 + hold_extra;
    nshift  = 0; nadd = 0; nclr = 0; nbusy = 0; ndone = 0; nldb = 0;
    aborted = 1'b0;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge Clk);
      if (c == abort_at) begin
        Reset        = 1'b0;
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        M            = 1'b1;
        #1;
        check($sformatf("abort_same_cycle c=%0d", c), 32'(outs()), 32'(0));
        @(negedge Clk);
        #1;
        check("abort_held", 32'(outs()), 32'(0));
        aborted = 1'b1;
        break;
      end
      if (c == 0) begin
        Reset        = 1'b1;
        Run          = 1'b1;
        ClearA_LoadB = clr_with_run;
        M            = 1'($urandom);
      end else if (c <= 2 * W + 1) begin
        Run          = 1'($urandom);
        ClearA_LoadB = 1'($urandom);
        M            = ((c % 2) == 0) ? b[(c - 2) / 2] : 1'($urandom);
      end else if (c <= last) begin
        Run          = 1'b1;
        ClearA_LoadB = 1'($urandom);
        M            = 1'($urandom);
      end else begin
        Run          = 1'b0;
        ClearA_LoadB = 1'($urandom);
        M            = 1'($urandom);
      end
      #1;
      got = outs();
      e   = expect_out(c, b);
      check($sformatf("b=%02h c=%0d", b, c), 32'(got), 32'(e));
      nshift += int'(got[P_SHF]);
      nadd   += int'(got[P_ADD]);
      nclr   += int'(got[P_CLR] && got[P_BSY]);
      nbusy  += int'(got[P_BSY]);
      ndone  += int'(got[P_DON]);
      nldb   += int'(got[P_LDB]);
    end
    if (!aborted) begin
      check($sformatf("shift_pulses b=%02h", b), 32'(nshift), 32'(W));
      check($sformatf("add_pulses b=%02h", b), 32'(nadd), 32'($countones(b)));
      check($sformatf("clear_cycles b=%02h", b), 32'(nclr), 32'(1));
      check($sformatf("busy_cycles b=%02h", b), 32'(nbusy), 32'(2 * W + 1));
      check($sformatf("done_pulses b=%02h", b), 32'(ndone), 32'(1));
      check($sformatf("ld_b_pulses b=%02h", b), 32'(nldb), 32'(0));
    end
  endtask

  initial begin
    Reset        = 1'b0;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    M            = 1'b1;
    #3;
    check("reset_initial", 32'(outs()), 32'(0));
    repeat (3) @(negedge Clk);
    #1;
    check("reset_held", 32'(outs()), 32'(0));

    @(negedge Clk);
    Reset = 1'b1;
    Run   = 1'b0;
    #1;
    check("idle_after_reset_load", 32'(outs()), 32'(7'b1100000));
    idle_cycles(1, 1'b1);
    idle_cycles(4, 1'b0);

    do_mult(8'h07, 0, 1'b0, -1);
    idle_cycles(2, 1'b0);
    do_mult(8'h80, 10, 1'b0, -1);
    idle_cycles(1, 1'b1);
    do_mult(8'h5A, 0, 1'b1, -1);

    // Abort in SHIFT3 (c = 3 + 2*3), then restart with Run already high at release.
    do_mult(8'hFF, 0, 1'b0, 9);
    do_mult(8'hC3, 0, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      idle_cycles(int'($urandom_range(0, 2)), 1'b0);
      do_mult(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom), -1);
    end
    idle_cycles(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
